cbus_arbiter_n: RTL and testbench
=================================

CBUS_ARBITER_N -- requirements
Module: cbus_arbiter_n

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, giving the number of cache-bus master channels (legal range 2..16).
REQ-002 SHALL have parameter IDX_W, default $clog2(NUM_CH), giving the grant index width.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port ireqs  input  NUM_CH x cbus_req_t  per-channel burst requests.
REQ-006 SHALL have port iresps  output  NUM_CH x cbus_resp_t  per-channel responses.
REQ-007 SHALL have port oreq  output  cbus_req_t  the arbitrated request to the downstream cache bus.
REQ-008 SHALL have port oresp  input  cbus_resp_t  the downstream response.
REQ-009 SHALL have port busy  output  1  high while a grant is held.
REQ-010 SHALL have port grant_idx  output  IDX_W  index of the current or last owner.
REQ-011 SHALL have port len_err  output  1  one-cycle pulse on a burst-length mismatch.

Function
REQ-012 SHALL implement a 2-state FSM: IDLE and BUSY.
REQ-013 In IDLE with at least one ireqs[i].valid, SHALL register the selected index, enter BUSY on the next edge, and clear the beat counter.
REQ-014 In IDLE, SHALL drive oreq to all-zero and every iresps[i] to all-zero.
REQ-015 In BUSY, SHALL drive oreq combinationally equal to ireqs[grant_idx], so per-beat data and strobe pass through with zero added latency.
REQ-016 In BUSY, SHALL drive iresps[grant_idx] = oresp and all other iresps to all-zero.
REQ-017 Request-to-oreq.valid latency SHALL be exactly 1 cycle.
REQ-018 Grant SHALL be held until oresp.ready && oresp.last, even if the owner drops valid mid-burst (oreq.valid then follows the owner's valid).
REQ-019 On the ready && last edge, SHALL return to IDLE; a new grant SHALL not issue in that same cycle, giving one mandatory idle cycle between bursts.
REQ-020 SHALL count beats (oresp.ready) in a 9-bit counter during BUSY.
REQ-021 At the last beat, if count+1 != oreq.len+1, SHALL pulse len_err high for exactly the cycle after the last beat; otherwise len_err SHALL stay 0.
REQ-022 Fixed priority (macro absent): SHALL grant the lowest valid index.
REQ-023 busy SHALL equal (state == BUSY).
REQ-024 grant_idx SHALL hold its value in IDLE.

Reset
REQ-025 On reset, SHALL set state = IDLE, grant_idx = 0, beat counter = 0, len_err = 0, and the round-robin pointer = 0; oreq and all iresps SHALL read zero in the following cycle.
REQ-026 Reset asserted mid-burst SHALL abandon the transaction immediately, with no len_err pulse; the downstream side is reset with the arbiter.

Configuration
REQ-027 With CBUS_ARB_ROUND_ROBIN_EN defined, SHALL grant the first valid index at or after the pointer (cyclic search over NUM_CH) and, on burst completion, set pointer = (grant_idx + 1) mod NUM_CH.
REQ-028 Without CBUS_ARB_ROUND_ROBIN_EN, SHALL use fixed priority per REQ-022, and the pointer register SHALL not exist.

Verification
REQ-029 Reset, then ch0 alone requests len=MLEN4 with 4 ready beats, last on beat 4 -> oreq.valid rises 1 cycle after the request; iresps[0] sees 4 beats; busy drops after beat 4; len_err=0.
REQ-030 NUM_CH=4, ch1 and ch3 request simultaneously, MLEN1 each -> ch1 is served, one idle cycle follows, then ch3; iresps[3] stays zero during ch1's burst.
REQ-031 CBUS_ARB_ROUND_ROBIN_EN defined, NUM_CH=2, both channels request continuously for 4 single-beat bursts -> grant order 0,1,0,1; without the macro -> 0,0,0,0.
REQ-032 len=MLEN4 but last asserted on beat 2 -> FSM returns to IDLE and len_err pulses for exactly 1 cycle.
REQ-033 Reset asserted at beat 2 of an MLEN8 burst -> next cycle busy=0, oreq=0, grant_idx=0, and no len_err.
REQ-034 Owner drops valid at beat 2 of an MLEN4 burst -> oreq.valid=0, grant still held, and no other channel is granted until last.

Source files
------------

// File: rtl/cbus_arbiter_n.sv
// ---------------------------------------------------------------------------
// cbus_arbiter_n -- N-channel cache-bus burst arbiter
//
// Grants one of NUM_CH burst masters to a single downstream cache bus and
// holds that grant until the downstream side returns ready && last. The
// selected request, including its per-beat data and strobe, passes to oreq
// combinationally with no added latency. The granted channel sees oresp on
// its iresps slot, and every other channel sees zeros. One idle cycle always
// separates consecutive bursts.
//
// Optional feature macro: CBUS_ARB_ROUND_ROBIN_EN
//   undefined : fixed priority, the lowest valid index wins
//   defined   : round robin, the first valid index at or after a pointer
//               wins; the pointer moves past the owner when a burst ends
//
// Parameters
//   NUM_CH  number of master channels (2..16)
//   IDX_W   grant index width
//
// Ports
//   clk        in   clock; all state changes on its rising edge
//   reset      in   synchronous, active-high reset
//   ireqs      in   per-channel burst requests      [NUM_CH] cbus_req_t
//   iresps     out  per-channel responses           [NUM_CH] cbus_resp_t
//   oreq       out  arbitrated downstream request   cbus_req_t
//   oresp      in   downstream response             cbus_resp_t
//   busy       out  high while a grant is held
//   grant_idx  out  index of the current or last owner
//   len_err    out  one-cycle pulse after a last beat whose burst length
//                   did not match the request length
// ---------------------------------------------------------------------------
package cbus_arbiter_n_pkg;
  // len encodes (beats - 1)
  localparam logic [7:0] MLEN1 = 8'd0;
  localparam logic [7:0] MLEN2 = 8'd1;
  localparam logic [7:0] MLEN4 = 8'd3;
  localparam logic [7:0] MLEN8 = 8'd7;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [31:0] data;
    logic [3:0]  strb;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] rdata;
  } cbus_resp_t;
endpackage

module cbus_arbiter_n
  import cbus_arbiter_n_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int IDX_W  = $clog2(NUM_CH)
) (
  input  logic             clk,
  input  logic             reset,
  input  cbus_req_t        ireqs  [NUM_CH],
  output cbus_resp_t       iresps [NUM_CH],
  output cbus_req_t        oreq,
  input  cbus_resp_t       oresp,
  output logic             busy,
  output logic [IDX_W-1:0] grant_idx,
  output logic             len_err
);

  typedef enum logic {S_IDLE, S_BUSY} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [8:0]       cnt_q, cnt_d;
  logic             len_err_q, len_err_d;
  logic             sel_valid;
  logic [IDX_W-1:0] sel_idx;
  logic             done;

`ifdef CBUS_ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] ptr_q, ptr_d;
  int               cand;
`endif

  // Winner selection among currently valid requests
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
`ifdef CBUS_ARB_ROUND_ROBIN_EN
    cand      = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = (int'(ptr_q) + k) % NUM_CH;
      if (!sel_valid && ireqs[cand].valid) begin
        sel_valid = 1'b1;
        sel_idx   = IDX_W'(cand);
      end
    end
`else
    // Scan downward so the lowest valid index is the last one written
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (ireqs[k].valid) begin
        sel_valid = 1'b1;
        sel_idx   = IDX_W'(k);
      end
    end
`endif
  end

  // Next state and datapath muxing
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    cnt_d     = cnt_q;
    len_err_d = 1'b0;
    done      = 1'b0;
    oreq      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      iresps[i] = '0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (sel_valid) begin
          state_d = S_BUSY;
          grant_d = sel_idx;
          cnt_d   = '0;
        end
      end
      S_BUSY: begin
        // The owner's valid passes through as well, so a mid-burst drop is
        // visible downstream while the grant stays put
        oreq            = ireqs[grant_q];
        iresps[grant_q] = oresp;
        if (oresp.ready) begin
          cnt_d = cnt_q + 9'd1;
        end
        if (oresp.ready && oresp.last) begin
          state_d   = S_IDLE;
          done      = 1'b1;
          len_err_d = (cnt_q + 9'd1) != ({1'b0, ireqs[grant_q].len} + 9'd1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef CBUS_ARB_ROUND_ROBIN_EN
  always_comb begin
    ptr_d = ptr_q;
    if (done) begin
      ptr_d = (grant_q == IDX_W'(NUM_CH - 1)) ? '0 : grant_q + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      cnt_q     <= '0;
      len_err_q <= 1'b0;
`ifdef CBUS_ARB_ROUND_ROBIN_EN
      ptr_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      cnt_q     <= cnt_d;
      len_err_q <= len_err_d;
`ifdef CBUS_ARB_ROUND_ROBIN_EN
      ptr_q     <= ptr_d;
`endif
    end
  end

  assign busy      = (state_q == S_BUSY);
  assign grant_idx = grant_q;
  assign len_err   = len_err_q;

endmodule

// File: tb/tb_cbus_arbiter_n.sv
// ---------------------------------------------------------------------------
// tb_cbus_arbiter_n -- self-checking bench for cbus_arbiter_n (NUM_CH = 4)
//
// Table of cycle vectors for the basic burst, two-channel contention and
// short-burst length error; hand-written sequences for reset mid-burst,
// owner dropping valid, and back-to-back grant order; then random traffic
// against a behavioural model. Honours CBUS_ARB_ROUND_ROBIN_EN.
// ---------------------------------------------------------------------------
module tb_cbus_arbiter_n;
  import cbus_arbiter_n_pkg::*;

  localparam int NCH = 4;

  logic       clk;
  logic       rst;
  cbus_req_t  reqs   [NCH];
  cbus_resp_t dresps [NCH];
  cbus_req_t  doreq;
  cbus_resp_t rsp;
  logic       dbusy;
  logic [1:0] dgrant;
  logic       dlerr;

  int n_vec = 0;
  int n_err = 0;

  // expected values for the current check
  logic       e_busy;
  int         e_gidx;
  logic       e_lerr;
  cbus_req_t  e_oreq;
  cbus_resp_t e_resp [NCH];

  cbus_arbiter_n #(.NUM_CH(NCH)) dut (
    .clk       (clk),
    .reset     (rst),
    .ireqs     (reqs),
    .iresps    (dresps),
    .oreq      (doreq),
    .oresp     (rsp),
    .busy      (dbusy),
    .grant_idx (dgrant),
    .len_err   (dlerr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         chk;
    bit         r;
    logic [3:0] vm;
    logic [7:0] ln;
    bit         rdy;
    bit         lst;
    bit         eb;
    int         eg;
    bit         el;
  } vec_t;

  vec_t tbl [19];

  task automatic drive(input logic [3:0] vm, input logic [7:0] ln,
                       input bit rdy, input bit lst, input bit r);
    rst = r;
    for (int i = 0; i < NCH; i++) begin
      reqs[i].valid = vm[i];
      reqs[i].addr  = 32'h1000 * (i + 1);
      reqs[i].len   = ln;
      reqs[i].data  = $urandom;
      reqs[i].strb  = 4'($urandom);
    end
    rsp.ready = rdy;
    rsp.last  = lst;
    rsp.rdata = $urandom;
  endtask

  // owner < 0 means nobody holds the bus
  task automatic set_exp(input int owner, input int eg, input bit el);
    e_busy = (owner >= 0);
    e_gidx = eg;
    e_lerr = el;
    e_oreq = (owner >= 0) ? reqs[owner] : '0;
    for (int i = 0; i < NCH; i++) e_resp[i] = (i == owner) ? rsp : '0;
  endtask

  task automatic compare(input string nm);
    bit bad;
    bad = 0;
    n_vec++;
    if (dbusy !== e_busy) begin
      $display("FAIL %s busy: got %0b want %0b", nm, dbusy, e_busy); bad = 1;
    end
    if (dgrant !== 2'(e_gidx)) begin
      $display("FAIL %s grant_idx: got %0d want %0d", nm, dgrant, e_gidx); bad = 1;
    end
    if (dlerr !== e_lerr) begin
      $display("FAIL %s len_err: got %0b want %0b", nm, dlerr, e_lerr); bad = 1;
    end
    if (doreq !== e_oreq) begin
      $display("FAIL %s oreq: got %h want %h", nm, doreq, e_oreq); bad = 1;
    end
    for (int i = 0; i < NCH; i++) begin
      if (dresps[i] !== e_resp[i]) begin
        $display("FAIL %s iresps[%0d]: got %h want %h", nm, i, dresps[i], e_resp[i]);
        bad = 1;
      end
    end
    if (bad) n_err++;
  endtask

  // one clock: drive, check mid-cycle, advance past the edge
  task automatic cyc(input logic [3:0] vm, input logic [7:0] ln, input bit rdy,
                     input bit lst, input bit r, input bit chk, input bit eb,
                     input int eg, input bit el, input string nm);
    drive(vm, ln, rdy, lst, r);
    @(negedge clk);
    if (chk) begin
      set_exp(eb ? eg : -1, eg, el);
      compare(nm);
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural reference model ----------------
  int m_owner, m_beats, m_ptr, m_last;
  bit m_err;

  function automatic int pick(input int ptr);
`ifdef CBUS_ARB_ROUND_ROBIN_EN
    for (int k = 0; k < NCH; k++) begin
      if (reqs[(ptr + k) % NCH].valid) return (ptr + k) % NCH;
    end
`else
    for (int k = 0; k < NCH; k++) begin
      if (reqs[k].valid) return k;
    end
`endif
    return -1;
  endfunction

  task automatic model_edge();
    int w;
    if (rst) begin
      m_owner = -1; m_beats = 0; m_ptr = 0; m_last = 0; m_err = 0;
    end else if (m_owner >= 0) begin
      m_err = 0;
      if (rsp.ready) m_beats++;
      if (rsp.ready && rsp.last) begin
        m_err   = ((m_beats % 512) != int'(reqs[m_owner].len) + 1);
        m_ptr   = (m_owner + 1) % NCH;
        m_owner = -1;
      end
    end else begin
      m_err = 0;
      w = pick(m_ptr);
      if (w >= 0) begin
        m_owner = w; m_last = w; m_beats = 0;
      end
    end
  endtask

  int got [4];
  int ngot;
  int exp_order [4];

  initial begin
    //          chk r  vm       len    rdy lst eb eg el
    tbl[0]  = '{0, 1, 4'b0000, MLEN1, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 0, 4'b0000, MLEN1, 0, 0, 0, 0, 0};
    tbl[2]  = '{1, 0, 4'b0001, MLEN4, 0, 0, 0, 0, 0};
    tbl[3]  = '{1, 0, 4'b0001, MLEN4, 1, 0, 1, 0, 0};
    tbl[4]  = '{1, 0, 4'b0001, MLEN4, 1, 0, 1, 0, 0};
    tbl[5]  = '{1, 0, 4'b0001, MLEN4, 1, 0, 1, 0, 0};
    tbl[6]  = '{1, 0, 4'b0001, MLEN4, 1, 1, 1, 0, 0};
    tbl[7]  = '{1, 0, 4'b0000, MLEN4, 0, 0, 0, 0, 0};
    tbl[8]  = '{1, 0, 4'b0000, MLEN4, 0, 0, 0, 0, 0};
    tbl[9]  = '{1, 0, 4'b1010, MLEN1, 0, 0, 0, 0, 0};
    tbl[10] = '{1, 0, 4'b1010, MLEN1, 1, 1, 1, 1, 0};
    tbl[11] = '{1, 0, 4'b1000, MLEN1, 0, 0, 0, 1, 0};
    tbl[12] = '{1, 0, 4'b1000, MLEN1, 1, 1, 1, 3, 0};
    tbl[13] = '{1, 0, 4'b0000, MLEN1, 0, 0, 0, 3, 0};
    tbl[14] = '{1, 0, 4'b0001, MLEN4, 0, 0, 0, 3, 0};
    tbl[15] = '{1, 0, 4'b0001, MLEN4, 1, 0, 1, 0, 0};
    tbl[16] = '{1, 0, 4'b0001, MLEN4, 1, 1, 1, 0, 0};
    tbl[17] = '{1, 0, 4'b0000, MLEN4, 0, 0, 0, 0, 1};
    tbl[18] = '{1, 0, 4'b0000, MLEN4, 0, 0, 0, 0, 0};

    drive(4'b0000, MLEN1, 0, 0, 1);
    for (int i = 0; i < 19; i++) begin
      cyc(tbl[i].vm, tbl[i].ln, tbl[i].rdy, tbl[i].lst, tbl[i].r, tbl[i].chk,
          tbl[i].eb, tbl[i].eg, tbl[i].el, $sformatf("tbl%0d", i));
    end

    // reset at beat 2 of an 8-beat burst (last also raised, must not error)
    cyc(4'b0100, MLEN8, 0, 0, 0, 1, 0, 0, 0, "rst_req");
    cyc(4'b0100, MLEN8, 1, 0, 0, 1, 1, 2, 0, "rst_beat1");
    cyc(4'b0100, MLEN8, 1, 1, 1, 1, 1, 2, 0, "rst_beat2");
    cyc(4'b0000, MLEN8, 0, 0, 0, 1, 0, 0, 0, "rst_after");
    cyc(4'b0000, MLEN8, 0, 0, 0, 1, 0, 0, 0, "rst_nolerr");

    // owner drops valid mid-burst while another channel asks
    cyc(4'b0001, MLEN4, 0, 0, 0, 1, 0, 0, 0, "drop_req");
    cyc(4'b0001, MLEN4, 1, 0, 0, 1, 1, 0, 0, "drop_b1");
    cyc(4'b0010, MLEN4, 1, 0, 0, 1, 1, 0, 0, "drop_b2");
    cyc(4'b0010, MLEN4, 1, 0, 0, 1, 1, 0, 0, "drop_b3");
    cyc(4'b0011, MLEN4, 1, 1, 0, 1, 1, 0, 0, "drop_b4");
    cyc(4'b0010, MLEN4, 0, 0, 0, 1, 0, 0, 0, "drop_idle");
    cyc(4'b0000, MLEN1, 1, 1, 0, 1, 1, 1, 0, "drop_ch1");
    cyc(4'b0000, MLEN1, 0, 0, 0, 1, 0, 1, 0, "drop_end");

    // continuous requests from ch0 and ch1, single-beat bursts
`ifdef CBUS_ARB_ROUND_ROBIN_EN
    exp_order = '{0, 1, 0, 1};
`else
    exp_order = '{0, 0, 0, 0};
`endif
    cyc(4'b0000, MLEN1, 0, 0, 1, 0, 0, 0, 0, "order_rst");
    ngot = 0;
    for (int c = 0; c < 20 && ngot < 4; c++) begin
      drive(4'b0011, MLEN1, 1, 1, 0);
      @(negedge clk);
      if (dbusy === 1'b1) begin
        got[ngot] = int'(dgrant);
        ngot++;
      end
      @(posedge clk);
      #1;
    end
    if (ngot < 4) begin
      n_vec++; n_err++;
      $display("FAIL order_timeout: got %0d grants want 4", ngot);
    end
    for (int k = 0; k < ngot; k++) begin
      n_vec++;
      if (got[k] != exp_order[k]) begin
        n_err++;
        $display("FAIL order%0d: got %0d want %0d", k, got[k], exp_order[k]);
      end
    end

    // random traffic against the model
    drive(4'b0000, MLEN1, 0, 0, 1);
    @(negedge clk);
    model_edge();
    @(posedge clk);
    #1;
    for (int c = 0; c < 1500; c++) begin
      drive(4'($urandom_range(0, 15)), 8'($urandom_range(0, 3)),
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 59) == 0);
      @(negedge clk);
      set_exp(m_owner, m_last, m_err);
      compare($sformatf("rand%0d", c));
      model_edge();
      @(posedge clk);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
